// File: rtl/regwin_pkg.sv
// Shared definitions for the register-window controller: FSM encodings,
// transfer constants and the architectural-to-physical index function.
package regwin_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SPILL = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;

  localparam int unsigned NUM_XFER        = 16;
  localparam int unsigned XFER_FIRST_ARCH = 16;

  // Globals map 1:1; windowed registers live in a ring of 16*nwin entries above them.
  // w < nwin and arch < 32 keep the offset below 2*16*nwin, so one subtract replaces mod.
  function automatic int unsigned phys_idx(input int unsigned arch, input int unsigned w,
                                           input int unsigned nwin);
    int unsigned idx;
    int unsigned off;
    idx = arch;
    if (arch >= 8) begin
      off = 16 * w + arch - 8;
      if (off >= 16 * nwin) begin
        off = off - 16 * nwin;
      end
      idx = 8 + off;
    end
    return idx;
  endfunction

endpackage

// File: rtl/regwin_map.sv
// Combinational architectural-to-physical register index translator for one window.
module regwin_map
  import regwin_pkg::*;
#(
  parameter int unsigned NWINDOWS = 8,
  parameter int unsigned PHYS_W   = $clog2(8 + 16 * NWINDOWS)
) (
  input  logic [4:0]                    arch,
  input  logic [$clog2(NWINDOWS)-1:0]   win,
  output logic [PHYS_W-1:0]             phys
);

  assign phys = PHYS_W'(phys_idx(32'(arch), 32'(win), NWINDOWS));

endmodule

// File: rtl/regwin_ctrl.sv
// SPARC register-window controller: owns CWP/WIM, executes SAVE/RESTORE and
// runs a 16-word spill/fill engine over a valid/ready memory port.
module regwin_ctrl
  import regwin_pkg::*;
#(
  parameter int unsigned NWINDOWS = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned PHYS_W   = $clog2(8 + 16 * NWINDOWS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          save_req,
  input  logic                          restore_req,
  input  logic                          auto_spill_en,
  input  logic [ADDR_W-1:0]             frame_base,
  output logic                          op_done,
  output logic                          op_ovf,
  output logic                          op_unf,
  output logic                          busy,
  input  logic                          cwp_we,
  input  logic [$clog2(NWINDOWS)-1:0]   cwp_wdata,
  input  logic                          wim_we,
  input  logic [NWINDOWS-1:0]           wim_wdata,
  output logic [$clog2(NWINDOWS)-1:0]   cwp,
  output logic [NWINDOWS-1:0]           wim,
  input  logic [4:0]                    map_arch,
  output logic [PHYS_W-1:0]             map_phys,
  output logic [PHYS_W-1:0]             rf_rd_addr,
  input  logic [DATA_W-1:0]             rf_rd_data,
  output logic                          rf_wr_en,
  output logic [PHYS_W-1:0]             rf_wr_addr,
  output logic [DATA_W-1:0]             rf_wr_data,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_we,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic [DATA_W-1:0]             mem_req_wdata,
  input  logic                          mem_rsp_valid,
  input  logic [DATA_W-1:0]             mem_rsp_rdata
);

  localparam int unsigned CWP_W = $clog2(NWINDOWS);
  localparam logic [NWINDOWS-1:0] WimRst = {1'b1, {(NWINDOWS-1){1'b0}}};

  function automatic logic [CWP_W-1:0] win_dec(input logic [CWP_W-1:0] w);
    return (w == '0) ? CWP_W'(NWINDOWS - 1) : w - 1'b1;
  endfunction

  function automatic logic [CWP_W-1:0] win_inc(input logic [CWP_W-1:0] w);
    return (w == CWP_W'(NWINDOWS - 1)) ? '0 : w + 1'b1;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [CWP_W-1:0]    cwp_q, cwp_d;
  logic [CWP_W-1:0]    win_q, win_d;
  logic [CWP_W-1:0]    cwp_m1, cwp_p1;
  logic [NWINDOWS-1:0] wim_q, wim_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [3:0]          k_q, k_d;
  // SPILL: 0 = read issued, 1 = store presented. FILL: 0 = load presented, 1 = awaiting data.
  logic                phase_q, phase_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                wr_en_q, wr_en_d;
  logic [PHYS_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [4:0]          xfer_arch;
  logic [PHYS_W-1:0]   xfer_phys;
  logic                last_xfer;

  assign cwp_m1    = win_dec(cwp_q);
  assign cwp_p1    = win_inc(cwp_q);
  assign xfer_arch = 5'(XFER_FIRST_ARCH) + {1'b0, k_q};
  assign last_xfer = (k_q == 4'(NUM_XFER - 1));

  regwin_map #(
    .NWINDOWS (NWINDOWS),
    .PHYS_W   (PHYS_W)
  ) u_map_arch (
    .arch (map_arch),
    .win  (cwp_q),
    .phys (map_phys)
  );

  regwin_map #(
    .NWINDOWS (NWINDOWS),
    .PHYS_W   (PHYS_W)
  ) u_map_xfer (
    .arch (xfer_arch),
    .win  (win_q),
    .phys (xfer_phys)
  );

  always_comb begin
    state_d   = state_q;
    cwp_d     = cwp_q;
    wim_d     = wim_q;
    win_d     = win_q;
    base_d    = base_q;
    k_d       = k_q;
    phase_d   = phase_q;
    done_d    = 1'b0;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (cwp_we || wim_we) begin
          if (cwp_we) cwp_d = cwp_wdata;
          if (wim_we) wim_d = wim_wdata;
        // A held request must not be re-accepted in the cycle its result is reported.
        end else if (!(done_q || ovf_q || unf_q)) begin
          if (save_req) begin
            if (!wim_q[cwp_m1]) begin
              cwp_d  = cwp_m1;
              done_d = 1'b1;
            end else if (!auto_spill_en) begin
              ovf_d = 1'b1;
            end else begin
              base_d  = frame_base;
              win_d   = win_dec(cwp_m1);
              k_d     = '0;
              phase_d = 1'b0;
              state_d = SPILL;
            end
          end else if (restore_req) begin
            if (!wim_q[cwp_p1]) begin
              cwp_d  = cwp_p1;
              done_d = 1'b1;
            end else if (!auto_spill_en) begin
              unf_d = 1'b1;
            end else begin
              base_d  = frame_base;
              win_d   = cwp_p1;
              k_d     = '0;
              phase_d = 1'b0;
              state_d = FILL;
            end
          end
        end
      end
      SPILL: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (mem_req_ready) begin
          phase_d = 1'b0;
          if (last_xfer) begin
            wim_d   = {wim_q[0], wim_q[NWINDOWS-1:1]};
            cwp_d   = cwp_m1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      FILL: begin
        if (!phase_q) begin
          if (mem_req_ready) phase_d = 1'b1;
        end else if (mem_rsp_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = xfer_phys;
          wr_data_d = mem_rsp_rdata;
          phase_d   = 1'b0;
          if (last_xfer) begin
            wim_d   = {wim_q[NWINDOWS-2:0], wim_q[NWINDOWS-1]};
            cwp_d   = cwp_p1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cwp_q     <= '0;
      wim_q     <= WimRst;
      win_q     <= '0;
      base_q    <= '0;
      k_q       <= '0;
      phase_q   <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cwp_q     <= cwp_d;
      wim_q     <= wim_d;
      win_q     <= win_d;
      base_q    <= base_d;
      k_q       <= k_d;
      phase_q   <= phase_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Read address is held for the whole word, so rf_rd_data stays valid while the store waits.
  assign rf_rd_addr    = xfer_phys;
  assign mem_req_valid = ((state_q == SPILL) && phase_q) || ((state_q == FILL) && !phase_q);
  assign mem_req_we    = (state_q == SPILL);
  assign mem_req_addr  = base_q + ADDR_W'({k_q, 2'b00});
  assign mem_req_wdata = (state_q == SPILL) ? rf_rd_data : '0;

  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wr_data = wr_data_q;
  assign op_done    = done_q;
  assign op_ovf     = ovf_q;
  assign op_unf     = unf_q;
  assign busy       = (state_q != IDLE);
  assign cwp        = cwp_q;
  assign wim        = wim_q;

endmodule

// File: tb/tb_regwin_ctrl.sv
// Directed bench for regwin_ctrl (NWINDOWS=8) with memory and register-file scoreboards.
module tb_regwin_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        save_req, restore_req, auto_spill_en;
  logic [31:0] frame_base;
  logic        op_done, op_ovf, op_unf, busy;
  logic        cwp_we;
  logic [2:0]  cwp_wdata;
  logic        wim_we;
  logic [7:0]  wim_wdata;
  logic [2:0]  cwp;
  logic [7:0]  wim;
  logic [4:0]  map_arch;
  logic [7:0]  map_phys;
  logic [7:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        rf_wr_en;
  logic [7:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic        mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;

  always #5 clk = ~clk;

  regwin_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .save_req      (save_req),
    .restore_req   (restore_req),
    .auto_spill_en (auto_spill_en),
    .frame_base    (frame_base),
    .op_done       (op_done),
    .op_ovf        (op_ovf),
    .op_unf        (op_unf),
    .busy          (busy),
    .cwp_we        (cwp_we),
    .cwp_wdata     (cwp_wdata),
    .wim_we        (wim_we),
    .wim_wdata     (wim_wdata),
    .cwp           (cwp),
    .wim           (wim),
    .map_arch      (map_arch),
    .map_phys      (map_phys),
    .rf_rd_addr    (rf_rd_addr),
    .rf_rd_data    (rf_rd_data),
    .rf_wr_en      (rf_wr_en),
    .rf_wr_addr    (rf_wr_addr),
    .rf_wr_data    (rf_wr_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata)
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} mem_exp_t;
  typedef struct packed {logic [7:0] addr; logic [31:0] data;} rf_exp_t;

  mem_exp_t mem_sb[$];
  rf_exp_t  rf_sb[$];
  mem_exp_t m_pop;
  rf_exp_t  r_pop;

  int n_vec = 0, n_fail = 0;
  int acc_cnt = 0, done_cnt = 0, ovf_cnt = 0, unf_cnt = 0;
  int rsp_cnt = 0, stall_cnt = 0;
  int stall_at = -1;
  int stall_len = 5;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int tb_phys(input int r, input int w);
    if (r < 8) return r;
    return 8 + ((16 * w + r - 8) % 128);
  endfunction

  // Register file read port: one-cycle latency, recognisable data per index.
  always @(posedge clk) rf_rd_data <= 32'hD000_0000 | 32'(rf_rd_addr);

  // Memory model and output monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      mem_rsp_valid = (rsp_cnt == 0);
    end else begin
      mem_rsp_valid = 1'b0;
    end
    if (mem_req_valid && mem_req_we && acc_cnt == stall_at && stall_cnt < stall_len) begin
      mem_req_ready = 1'b0;
      stall_cnt++;
      if (mem_sb.size() > 0) begin
        chk("stall_addr", 64'(mem_req_addr), 64'(mem_sb[0].addr));
        chk("stall_wdata", 64'(mem_req_wdata), 64'(mem_sb[0].data));
      end
    end else begin
      mem_req_ready = 1'b1;
    end
    if (mem_req_valid && mem_req_ready) begin
      n_vec++;
      assert (mem_sb.size() > 0) else begin
        n_fail++;
        $error("FAIL mem_unexpected: got request addr 0x%0h expected none", mem_req_addr);
      end
      if (mem_sb.size() > 0) begin
        m_pop = mem_sb.pop_front();
        chk("mem_we", 64'(mem_req_we), 64'(m_pop.we));
        chk("mem_addr", 64'(mem_req_addr), 64'(m_pop.addr));
        if (m_pop.we) chk("mem_wdata", 64'(mem_req_wdata), 64'(m_pop.data));
      end
      acc_cnt++;
      if (!mem_req_we) begin
        rsp_cnt = 2;
        mem_rsp_rdata = 32'hA0 + 32'(mem_req_addr[5:2]);
      end
    end
    if (rf_wr_en) begin
      n_vec++;
      assert (rf_sb.size() > 0) else begin
        n_fail++;
        $error("FAIL rf_unexpected: got write addr %0d expected none", rf_wr_addr);
      end
      if (rf_sb.size() > 0) begin
        r_pop = rf_sb.pop_front();
        chk("rf_wr_addr", 64'(rf_wr_addr), 64'(r_pop.addr));
        chk("rf_wr_data", 64'(rf_wr_data), 64'(r_pop.data));
      end
    end
    if (op_done) done_cnt++;
    if (op_ovf) ovf_cnt++;
    if (op_unf) unf_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_done(input int maxc, output bit got);
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      tick();
      if (op_done) got = 1'b1;
    end
  endtask

  task automatic push_spill(input logic [31:0] base);
    for (int k = 0; k < 16; k++) begin
      mem_sb.push_back({1'b1, base + 32'(4 * k), 32'hD000_0000 | 32'(tb_phys(16 + k, 6))});
    end
  endtask

  bit got;
  int a0, d0;

  initial begin
    reset = 1'b0; save_req = 1'b0; restore_req = 1'b0; auto_spill_en = 1'b0;
    frame_base = '0; cwp_we = 1'b0; cwp_wdata = '0; wim_we = 1'b0; wim_wdata = '0;
    map_arch = '0;
    tick();
    tick();
    chk("rst_cwp", 64'(cwp), 64'd0);
    chk("rst_wim", 64'(wim), 64'h80);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pulses", 64'({op_done, op_ovf, op_unf}), 64'd0);
    chk("rst_strobes", 64'({mem_req_valid, rf_wr_en}), 64'd0);

    // 1: fast RESTORE straight out of reset
    reset = 1'b1;
    restore_req = 1'b1;
    tick();
    chk("s1_cwp", 64'(cwp), 64'd1);
    chk("s1_done", 64'(op_done), 64'd1);
    chk("s1_wim", 64'(wim), 64'h80);
    restore_req = 1'b0;
    map_arch = 5'd5;  #1 chk("map_glob", 64'(map_phys), 64'(tb_phys(5, 1)));
    map_arch = 5'd8;  #1 chk("map_out", 64'(map_phys), 64'(tb_phys(8, 1)));
    map_arch = 5'd31; #1 chk("map_in", 64'(map_phys), 64'(tb_phys(31, 1)));
    tick();
    tick();
    chk("s1_done_once", 64'(done_cnt), 64'd1);
    chk("s1_cwp_hold", 64'(cwp), 64'd1);

    // 2: overflow and underflow traps with auto spill disabled
    do_reset();
    a0 = acc_cnt;
    d0 = done_cnt;
    save_req = 1'b1;
    tick();
    chk("s2_ovf", 64'(op_ovf), 64'd1);
    chk("s2_cwp", 64'(cwp), 64'd0);
    chk("s2_wim", 64'(wim), 64'h80);
    save_req = 1'b0;
    tick();
    tick();
    chk("s2_ovf_once", 64'(ovf_cnt), 64'd1);
    chk("s2_no_mem", 64'(acc_cnt - a0), 64'd0);
    chk("s2_no_done", 64'(done_cnt - d0), 64'd0);
    cwp_we = 1'b1;
    cwp_wdata = 3'd6;
    tick();
    cwp_we = 1'b0;
    restore_req = 1'b1;
    tick();
    chk("s2_unf", 64'(op_unf), 64'd1);
    chk("s2_unf_cwp", 64'(cwp), 64'd6);
    restore_req = 1'b0;
    tick();
    chk("s2_unf_once", 64'(unf_cnt), 64'd1);

    // 3: automatic spill of window 6
    do_reset();
    a0 = acc_cnt;
    push_spill(32'h1000);
    auto_spill_en = 1'b1;
    frame_base = 32'h1000;
    save_req = 1'b1;
    tick();
    chk("s3_busy", 64'(busy), 64'd1);
    wait_done(200, got);
    save_req = 1'b0;
    chk("s3_done", 64'(got), 64'd1);
    chk("s3_busy_end", 64'(busy), 64'd0);
    chk("s3_cwp", 64'(cwp), 64'd7);
    chk("s3_wim", 64'(wim), 64'h40);
    chk("s3_stores", 64'(acc_cnt - a0), 64'd16);
    chk("s3_sb_empty", 64'(mem_sb.size()), 64'd0);
    map_arch = 5'd24; #1 chk("map_wrap", 64'(map_phys), 64'(tb_phys(24, 7)));

    // 4: software writes collide with RESTORE, then automatic fill of window 6
    a0 = acc_cnt;
    for (int k = 0; k < 16; k++) begin
      mem_sb.push_back({1'b0, 32'h2000 + 32'(4 * k), 32'h0});
      rf_sb.push_back({8'(tb_phys(16 + k, 6)), 32'hA0 + 32'(k)});
    end
    cwp_we = 1'b1; cwp_wdata = 3'd5;
    wim_we = 1'b1; wim_wdata = 8'h40;
    restore_req = 1'b1;
    frame_base = 32'h2000;
    tick();
    cwp_we = 1'b0;
    wim_we = 1'b0;
    chk("s4_sw_cwp", 64'(cwp), 64'd5);
    chk("s4_sw_first", 64'(busy), 64'd0);
    tick();
    chk("s4_busy", 64'(busy), 64'd1);
    wait_done(400, got);
    restore_req = 1'b0;
    chk("s4_done", 64'(got), 64'd1);
    chk("s4_cwp", 64'(cwp), 64'd6);
    chk("s4_wim", 64'(wim), 64'h80);
    chk("s4_loads", 64'(acc_cnt - a0), 64'd16);
    chk("s4_sb_empty", 64'(mem_sb.size() + rf_sb.size()), 64'd0);

    // 5: spill with a 5-cycle ready stall on the k=3 store
    do_reset();
    a0 = acc_cnt;
    push_spill(32'h1000);
    stall_at = a0 + 3;
    frame_base = 32'h1000;
    save_req = 1'b1;
    wait_done(300, got);
    save_req = 1'b0;
    stall_at = -1;
    chk("s5_done", 64'(got), 64'd1);
    chk("s5_stall_len", 64'(stall_cnt), 64'd5);
    chk("s5_stores", 64'(acc_cnt - a0), 64'd16);
    chk("s5_sb_empty", 64'(mem_sb.size()), 64'd0);
    chk("s5_cwp", 64'(cwp), 64'd7);

    // 6: reset asserted at k=8 of a spill
    do_reset();
    a0 = acc_cnt;
    push_spill(32'h3000);
    frame_base = 32'h3000;
    save_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (acc_cnt - a0 >= 8) got = 1'b1;
    end
    chk("s6_reach_k8", 64'(got), 64'd1);
    tick();
    d0 = done_cnt;
    chk("s6_busy_pre", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("s6_busy", 64'(busy), 64'd0);
    chk("s6_cwp", 64'(cwp), 64'd0);
    chk("s6_wim", 64'(wim), 64'h80);
    chk("s6_valid", 64'(mem_req_valid), 64'd0);
    save_req = 1'b0;
    mem_sb.delete();
    tick();
    tick();
    tick();
    chk("s6_no_done", 64'(done_cnt - d0), 64'd0);
    reset = 1'b1;
    tick();
    chk("s6_idle_after", 64'({busy, cwp}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/regwin_ctrl.md
Name: regwin_ctrl

Overview:
- Register-window controller for the SPARC general register file.
- Owns CWP and WIM, and executes SAVE/RESTORE requests from the decode/execute stage.
- On window overflow or underflow it either raises a trap or runs an automatic spill/fill engine. The engine moves 16 registers between the register file and memory through a valid/ready memory port.
- Also provides the architectural-to-physical register index mapping used by the register file read/write ports.

Parameters:
NWINDOWS, 8, number of register windows (legal range 3..32)
DATA_W, 32, register and memory data width
ADDR_W, 32, memory address width
PHYS_W, $clog2(8+16*NWINDOWS), physical register index width (8 at default)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
save_req  in  1  SAVE request; held until op_done
restore_req  in  1  RESTORE request; held until op_done
auto_spill_en  in  1  1 = spill/fill in hardware, 0 = trap
frame_base  in  ADDR_W  word-aligned stack frame address for spill/fill, sampled when the request is accepted
op_done  out  1  one-cycle pulse: operation complete
op_ovf  out  1  one-cycle pulse: overflow trap (SAVE, auto_spill_en=0)
op_unf  out  1  one-cycle pulse: underflow trap (RESTORE, auto_spill_en=0)
busy  out  1  1 while in SPILL or FILL
cwp_we  in  1  software write of CWP (WRPSR)
cwp_wdata  in  $clog2(NWINDOWS)  new CWP
wim_we  in  1  software write of WIM
wim_wdata  in  NWINDOWS  new WIM
cwp  out  $clog2(NWINDOWS)  current window pointer
wim  out  NWINDOWS  window invalid mask
map_arch  in  5  architectural register number to translate
map_phys  out  PHYS_W  physical index of map_arch in the current window (combinational)
rf_rd_addr  out  PHYS_W  register file read index for spill
rf_rd_data  in  DATA_W  read data, valid one cycle after rf_rd_addr
rf_wr_en  out  1  register file write strobe for fill
rf_wr_addr  out  PHYS_W  fill write index
rf_wr_data  out  DATA_W  fill write data
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory request accepted
mem_req_we  out  1  1 = store (spill), 0 = load (fill)
mem_req_addr  out  ADDR_W  frame_base + 4*k
mem_req_wdata  out  DATA_W  spill data
mem_rsp_valid  in  1  load data valid
mem_rsp_rdata  in  DATA_W  load data

Behaviour:
- Reset (asynchronous, reset=0):
  - cwp=0; wim=1<<(NWINDOWS-1); state=IDLE.
  - All strobes and pulses 0, busy=0, rf_wr_en=0, mem_req_valid=0.
- Physical mapping, for window w and register r:
  - r in 0..7: phys = r.
  - r in 8..31: phys = 8 + ((16*w + r - 8) mod 16*NWINDOWS).
  - Consequence: the ins of w alias the outs of w+1.
- All window arithmetic is modulo NWINDOWS. SAVE decrements CWP; RESTORE increments it.
- IDLE, save_req=1:
  - If wim[cwp-1]=0: cwp<=cwp-1 and op_done pulses on the next cycle (1-cycle latency).
  - Else, if auto_spill_en=0: op_ovf pulses; cwp and wim unchanged.
  - Else: latch frame_base, latch O=cwp-2, and enter SPILL.
- IDLE, restore_req=1:
  - If wim[cwp+1]=0: cwp<=cwp+1 and op_done pulses on the next cycle.
  - Else, if auto_spill_en=0: op_unf pulses.
  - Else: latch frame_base, latch R=cwp+1, and enter FILL.
- save_req and restore_req both high in IDLE: SAVE wins. RESTORE is ignored and remains pending.
- SPILL: for k=0..15 in order, transfer arch register r16+k of window O.
  - Drive rf_rd_addr, then present mem_req_valid with mem_req_we=1, addr = base + 4k, wdata = rf_rd_data.
  - Hold valid, addr and wdata stable until mem_req_ready.
  - After k=15 is accepted: wim <= rotate-right-by-1, cwp <= cwp-1, op_done pulses, return to IDLE.
- FILL: for k=0..15, issue a load (mem_req_we=0) at base + 4k.
  - Only one load is outstanding at a time.
  - On mem_rsp_valid: rf_wr_en=1 for one cycle with rf_wr_addr = phys(r16+k, R) and rf_wr_data = mem_rsp_rdata.
  - After k=15 is written: wim <= rotate-left-by-1, cwp <= cwp+1, op_done pulses, return to IDLE.
- While busy=1, new save_req/restore_req are not accepted.
- Software writes:
  - cwp_we and wim_we are honoured only in IDLE and take effect next cycle.
  - If a software write and a request arrive in the same IDLE cycle, the software write has priority and the request is evaluated one cycle later.
  - cwp_we/wim_we while busy are dropped.
- mem_rsp_valid outside FILL is ignored.
- Reset asserted mid-SPILL/FILL: immediate return to the reset state. The partial transfer is abandoned and no op_done is generated.

Decomposition:
- Package regwin_pkg:
  - state enum {IDLE, SPILL, FILL}
  - function phys_idx(arch, w, nwin)
  - constants NUM_XFER=16 and XFER_FIRST_ARCH=16
- Sub-module regwin_map: combinational arch-to-physical translator. Instantiated for map_phys and reused internally for rf_rd_addr and rf_wr_addr.

Test Plan (NWINDOWS=8):
1. Release reset, restore_req=1 → cwp=1 on the next edge, op_done pulses once, wim=0x80.
2. After reset, save_req=1 with auto_spill_en=0 → op_ovf pulses, cwp stays 0, wim stays 0x80, no memory traffic.
3. After reset, save_req=1, auto_spill_en=1, frame_base=0x1000, mem_req_ready held 1:
   - Expect 16 stores at 0x1000..0x103C.
   - Data from phys 112..119 (locals of window 6), then 120..127 (ins).
   - Then cwp=7, wim=0x40, op_done.
4. Set cwp=5, wim=0x40 via software writes; restore_req with auto_spill_en=1, frame_base=0x2000; each load answered 2 cycles after accept with data 0xA0+k:
   - Expect 16 loads at 0x2000..0x203C.
   - rf writes: locals of window 6 at phys 112..119, then ins at 120..127, with matching data.
   - Then cwp=6, wim=0x80.
5. During the spill of scenario 3, hold mem_req_ready=0 for 5 cycles at k=3 → addr and wdata stable throughout; the k=3 store occurs exactly once.
6. Assert reset at k=8 of a spill → busy=0, cwp=0, wim=0x80 immediately; no op_done.
